ysyx_25060170_mem_arbiter: RTL
==============================

YSYX_25060170_MEM_ARBITER -- requirements
Module: ysyx_25060170_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 1024, WAIT-state cycles before an error response is issued (>=2).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 ifu_req_valid  in  1; ifu_req_ready  out  1; ifu_addr  in  32  IFU read request, valid/ready handshake.
REQ-005 ifu_resp_valid  out  1; ifu_rdata  out  32; ifu_resp_err  out  1  IFU single-cycle response.
REQ-006 lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_addr  in  32; lsu_wen  in  1; lsu_wdata  in  32; lsu_wmask  in  4  LSU request.
REQ-007 lsu_resp_valid  out  1; lsu_rdata  out  32; lsu_resp_err  out  1  LSU single-cycle response.
REQ-008 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  32; mem_wen  out  1; mem_wdata  out  32; mem_wmask  out  4  shared memory port request.
REQ-009 mem_resp_valid  in  1; mem_rdata  in  32  memory response; busy  out  1  high when state != IDLE.

Function
REQ-010 States: IDLE, REQ, WAIT; owner register (IFU/LSU); last_grant register; one outstanding transaction maximum.
REQ-011 IDLE: ifu_req_ready/lsu_req_ready combinational; exactly one asserted only for the granted requester, none if no valid.
REQ-012 Arbitration in IDLE: single valid -> grant it; both valid -> grant requester != last_grant (round-robin).
REQ-013 On grant: capture addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0) into mem_* registers, set owner and last_grant, go REQ.
REQ-014 REQ: mem_req_valid=1, payload stable; mem_req_ready=1 -> WAIT next cycle, else remain REQ (no timeout in REQ).
REQ-015 WAIT: mem_req_valid=0; mem_resp_valid=1 -> owner resp_valid=1, rdata=mem_rdata, resp_err=0 same cycle (combinational), IDLE next cycle.
REQ-016 WAIT counter: cleared on WAIT entry, increments per WAIT cycle without response; in the WAIT cycle where counter == TIMEOUT_CYC-1 with no response, owner resp_valid=1, resp_err=1, rdata=0, IDLE next cycle.
REQ-017 mem_resp_valid and mem_rdata ignored in IDLE and REQ (late/stray responses dropped).
REQ-018 Non-owner resp_valid, resp_err always 0; rdata on non-owner and non-response cycles = 0.
REQ-019 Minimum latency: grant cycle N, mem_req_valid at N+1, response earliest N+2, next grant earliest N+3.
REQ-020 Requester deasserting valid after grant has no effect; transaction completes.
REQ-021 Counter width ceil(log2(TIMEOUT_CYC)) bits; no wrap possible before timeout fires.

Reset
REQ-022 rst low -> immediately: state IDLE, owner=IFU, last_grant=IFU (first tie goes to LSU), counter 0, all mem_* outputs 0, all resp outputs 0, busy 0.
REQ-023 Reset mid-REQ/WAIT aborts transaction with no response; post-reset memory response ignored per REQ-017.
REQ-024 Release of rst takes effect at next rising clk; first grant possible that cycle.

Verification
REQ-025 Single IFU read addr 0x80000000, mem_req_ready=1 at N+1, mem_resp_valid rdata 0x00100073 at N+2 -> ifu_resp_valid=1, ifu_rdata=0x00100073 at N+2, busy 0 at N+3.
REQ-026 IFU and LSU valid same cycle after reset -> LSU granted first; both held -> IFU granted next, then LSU; grants alternate.
REQ-027 LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low 5 cycles -> mem_req_valid held, payload unchanged 5 cycles, then WAIT.
REQ-028 TIMEOUT_CYC=4, no mem_resp_valid -> lsu_resp_valid=1, lsu_resp_err=1, lsu_rdata=0 in 4th WAIT cycle; late mem_resp_valid next cycle produces no response.
REQ-029 rst low during WAIT -> mem_req_valid, busy, all resp outputs 0 before next clk edge; subsequent mem_resp_valid ignored; next request serviced normally.

Source files
------------

// File: rtl/ysyx_25060170_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_mem_arbiter_if
// Purpose  : Bundles the IFU request/response, LSU request/response and shared
//            memory port signals of the memory arbiter.
// Modports : master - arbiter view (accepts IFU/LSU requests, drives memory)
//            slave  - environment view (requesters and memory model)
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25060170_mem_arbiter_if;
  // IFU read channel
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  // LSU read/write channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  // Shared memory port
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  // Status
  logic        busy;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25060170_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_mem_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between IFU and LSU.
//            One outstanding transaction; WAIT-state timeout returns an error.
// Ports    : clk - clock, all state on rising edge
//            rst - asynchronous active-low reset
//            bus - ysyx_25060170_mem_arbiter_if.master (IFU, LSU, memory, busy)
// Params   : TIMEOUT_CYC - WAIT cycles without response before error (>=2)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_mem_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_25060170_mem_arbiter_if.master        bus
);

  localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic c_IFU = 1'b0;
  localparam logic c_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic                 r_last_grant;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_mem_addr;
  logic                 r_mem_wen;
  logic [31:0]          r_mem_wdata;
  logic [3:0]           r_mem_wmask;

  logic                 w_grant_ifu;
  logic                 w_grant_lsu;
  logic                 w_resp_fire;
  logic                 w_resp_err;
  logic [31:0]          w_resp_rdata;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, grants and response generation
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_ifu  = 1'b0;
    w_grant_lsu  = 1'b0;
    w_resp_fire  = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time is served
        w_grant_ifu = bus.ifu_req_valid & (~bus.lsu_req_valid | (r_last_grant == c_LSU));
        w_grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | (r_last_grant == c_IFU));
        if (w_grant_ifu || w_grant_lsu) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A real response in the last allowed cycle still wins over the timeout
        if (bus.mem_resp_valid) begin
          w_resp_fire  = 1'b1;
          w_resp_rdata = bus.mem_rdata;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_resp_fire  = 1'b1;
          w_resp_err   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, ownership and WAIT counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= c_IFU;
      r_last_grant <= c_IFU;
      r_cnt        <= '0;
      r_mem_addr   <= 32'h0;
      r_mem_wen    <= 1'b0;
      r_mem_wdata  <= 32'h0;
      r_mem_wmask  <= 4'h0;
    end else begin
      if (w_grant_ifu) begin
        r_owner      <= c_IFU;
        r_last_grant <= c_IFU;
        r_mem_addr   <= bus.ifu_addr;
        r_mem_wen    <= 1'b0;
        r_mem_wdata  <= 32'h0;
        r_mem_wmask  <= 4'h0;
      end else if (w_grant_lsu) begin
        r_owner      <= c_LSU;
        r_last_grant <= c_LSU;
        r_mem_addr   <= bus.lsu_addr;
        r_mem_wen    <= bus.lsu_wen;
        r_mem_wdata  <= bus.lsu_wdata;
        r_mem_wmask  <= bus.lsu_wmask;
      end
      // Held at zero while in REQ so every WAIT entry starts from zero
      if (r_state == S_REQ) r_cnt <= '0;
      else if (r_state == S_WAIT && !w_resp_fire) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.ifu_req_ready  = w_grant_ifu;
  assign bus.lsu_req_ready  = w_grant_lsu;

  assign bus.mem_req_valid  = (r_state == S_REQ);
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wen        = r_mem_wen;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_wmask      = r_mem_wmask;

  assign bus.ifu_resp_valid = w_resp_fire & (r_owner == c_IFU);
  assign bus.ifu_resp_err   = w_resp_err  & (r_owner == c_IFU);
  assign bus.ifu_rdata      = (r_owner == c_IFU) ? w_resp_rdata : 32'h0;
  assign bus.lsu_resp_valid = w_resp_fire & (r_owner == c_LSU);
  assign bus.lsu_resp_err   = w_resp_err  & (r_owner == c_LSU);
  assign bus.lsu_rdata      = (r_owner == c_LSU) ? w_resp_rdata : 32'h0;

  assign bus.busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
